imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate extender for the MIPS datapath.
//  Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes:
//  sign, zero, upper (LUI) and branch offset (sign-extended, shifted left by 2).
//  A valid/ready handshake with a 2-entry skid buffer lets decode and execute
//  stall independently.
//  Sits between instruction decode and the ALU operand mux.
// PARAMETERS
//  IN_W   16  immediate input width
//  OUT_W  32  extended output width; OUT_W >= IN_W+2 is a hard requirement
//  TAG_W  5   sideband tag width (e.g. destination register index), passed through unchanged
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      upstream has an immediate
//  in_ready   out  1      block can accept this cycle
//  data_in    in   IN_W   raw immediate
//  mode       in   2      extension mode, sampled with data_in
//  tag_in     in   TAG_W  sideband, travels with data
//  out_valid  out  1      data_out/tag_out hold a result
//  out_ready  in   1      downstream accepts this cycle
//  data_out   out  OUT_W  extended immediate
//  tag_out    out  TAG_W  tag of the data_out entry
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - out_valid=0, data_out=0, tag_out=0, skid empty, in_ready=1.
//   - Any pending entries are discarded.
//  Modes (combinational on accepted input; m = data_in[IN_W-1])
//   - 2'b00 SIGN:   {(OUT_W-IN_W){m}, data_in}
//   - 2'b01 ZERO:   {(OUT_W-IN_W){1'b0}, data_in}
//   - 2'b10 UPPER:  data_in << (OUT_W-IN_W), low bits 0
//   - 2'b11 BRANCH: {(OUT_W-IN_W-2){m}, data_in, 2'b00}
//  Handshake
//   - Accept on in_valid && in_ready. Transfer out on out_valid && out_ready.
//   - in_ready = !skid_valid, taken straight from a register (no combinational path from out_ready).
//   - Latency: an input accepted at edge k is visible on data_out after edge k.
//   - Throughput: 1 result/cycle while out_ready=1.
//  Per-edge update
//   - If the output register is empty or being drained:
//     - skid full  -> output reg <- skid; skid <- accepted input, if any.
//     - skid empty -> output reg <- accepted input; out_valid <- accept.
//   - If the output register is full and stalled:
//     - an accepted input goes to the skid register; in_ready drops at the next edge.
//  Boundaries
//   - Simultaneous accept and drain with skid empty: pass-through, no bubble.
//   - Skid full and drained: the skid entry moves to output, and in_ready rises the following cycle.
//   - Order is strictly FIFO: no loss and no duplication.
//   - While out_valid && !out_ready, data_out and tag_out are held stable.
//   - in_valid while in_ready=0 is ignored; upstream must hold the input.
//   - rst_n asserted mid-stall: all outputs clear immediately (async).
// STRUCTURE
//  Package imm_ext_pkg
//   - localparams MODE_SIGN=2'b00, MODE_ZERO=2'b01, MODE_UPPER=2'b10, MODE_BRANCH=2'b11.
//   - function imm_extend(data, mode).
//  Sub-module skid_buffer #(W)
//   - Generic 2-entry valid/ready register slice.
//   - Instantiated with W = OUT_W+TAG_W.
//   - The extend function sits on its input side.
// TESTING
//  1. SIGN 16'h8001, out_ready=1 -> data_out=32'hFFFF8001, out_valid exactly one cycle after accept.
//  2. ZERO 16'h8001 -> 32'h00008001; UPPER 16'h1234 -> 32'h12340000; BRANCH 16'hFFFF -> 32'hFFFFFFFC.
//  3. 8 back-to-back inputs, out_ready=1 -> 8 consecutive results in order; in_ready stays 1.
//  4. Stream with out_ready=0:
//     - 2 inputs are accepted and in_ready=0 from the next cycle.
//     - data_out is stable while stalled.
//     - Releasing out_ready delivers both results in order, and in_ready returns 1 a cycle later.
//  5. rst_n low while skid full -> out_valid=0 and data_out=0 immediately, in_ready=1; no stale result after release.
//  6. Random in_valid/out_ready, 1000 items, random modes/tags -> scoreboard matches imm_extend and tag order exactly.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Immediate-extension helpers shared by the decode-side extend pipeline.
// Latency: purely combinational function, no state.
// Backpressure: not applicable (no handshake in this package).
package imm_ext_pkg;

  // Extension modes, sampled alongside the raw immediate
  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  // Working width of imm_extend; callers slice the low out_w bits
  localparam int EXT_MAX_W = 64;

  // Widen the low in_w bits of data to out_w bits according to mode.
  // Widths are arguments so one function serves any instantiation;
  // with constant widths the masks and shifts fold to plain wiring.
  function automatic logic [EXT_MAX_W-1:0] imm_extend(
    input logic [EXT_MAX_W-1:0] data,
    input logic [1:0]           mode,
    input int                   in_w,
    input int                   out_w
  );
    logic [EXT_MAX_W-1:0] in_mask;
    logic [EXT_MAX_W-1:0] out_mask;
    logic [EXT_MAX_W-1:0] top_bit;
    logic [EXT_MAX_W-1:0] d;
    logic [EXT_MAX_W-1:0] sext;
    logic [EXT_MAX_W-1:0] r;
    logic                 m;
    in_mask  = {EXT_MAX_W{1'b1}} >> (EXT_MAX_W - in_w);
    out_mask = {EXT_MAX_W{1'b1}} >> (EXT_MAX_W - out_w);
    top_bit  = in_mask & ~(in_mask >> 1);
    d        = data & in_mask;
    m        = |(d & top_bit);
    sext     = d | (m ? ~in_mask : '0);
    case (mode)
      MODE_SIGN:   r = sext;
      MODE_ZERO:   r = d;
      MODE_UPPER:  r = d << (out_w - in_w);
      default:     r = sext << 2;   // MODE_BRANCH: word offset to byte offset
    endcase
    return r & out_mask;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready register slice (output reg + skid reg).
// Latency: 1 cycle input-to-output; full throughput while out_ready is high.
// Backpressure: in_ready is a flop (!skid_valid); one extra beat is absorbed on stall.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_vld_q;
  logic [W-1:0] out_dat_q;
  logic         skid_vld_q;
  logic [W-1:0] skid_dat_q;
  logic         accept;
  logic         out_free;

  // in_ready comes straight from the skid flag so out_ready never reaches upstream combinationally
  assign in_ready  = !skid_vld_q;
  assign accept    = in_valid && in_ready;
  assign out_free  = !out_vld_q || out_ready;
  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;

  // Output register refills from skid first (keeps FIFO order), else from the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else if (out_free) begin
      if (skid_vld_q) begin
        out_vld_q  <= 1'b1;
        out_dat_q  <= skid_dat_q;
        skid_vld_q <= accept;
        if (accept) skid_dat_q <= in_data;
      end else begin
        out_vld_q <= accept;
        if (accept) out_dat_q <= in_data;
      end
    end else if (accept) begin
      // Output held by a stalled consumer: park the new beat in the skid slot
      skid_vld_q <= 1'b1;
      skid_dat_q <= in_data;
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign/zero/upper/branch) between decode and ALU operand mux.
// Latency: 1 cycle (input accepted at edge k is on data_out after edge k); 1 result/cycle.
// Backpressure: 2-entry skid buffer; in_ready is registered and drops once the skid slot fills.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,   // must be at least IN_W+2 so the branch shift loses nothing
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic [TAG_W-1:0] tag_out
);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } ext_entry_t;

  logic [EXT_MAX_W-1:0] ext_full;
  ext_entry_t           in_entry;
  ext_entry_t           out_entry;

  // Reject parameter sets the extend function cannot represent
  if (OUT_W < IN_W + 2 || OUT_W > EXT_MAX_W) begin : g_bad_widths
    $error("imm_extend_pipe: need IN_W+2 <= OUT_W <= EXT_MAX_W");
  end

  // Extend on the input side so only finished results are buffered
  always_comb begin
    ext_full      = imm_extend(EXT_MAX_W'(data_in), mode, IN_W, OUT_W);
    in_entry.data = ext_full[OUT_W-1:0];
    in_entry.tag  = tag_in;
  end

  // Bits above OUT_W are always zero from imm_extend
  if (OUT_W < EXT_MAX_W) begin : g_ext_hi
    logic unused_ext_hi;
    assign unused_ext_hi = ^ext_full[EXT_MAX_W-1:OUT_W];
  end

  skid_buffer #(
    .W($bits(ext_entry_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  assign data_out = out_entry.data;
  assign tag_out  = out_entry.tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed cases plus randomized scoreboard run.
// Latency: expects results one edge after acceptance.
// Backpressure: exercises stalls, skid fill/drain and reset while full.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] data_in = '0;
  logic [1:0]  mode = '0;
  logic [4:0]  tag_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] data_out;
  logic [4:0]  tag_out;

  int n_checks = 0;
  int n_fail   = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .mode      (mode),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the four modes as plain integer arithmetic on a 16-bit immediate
  function automatic logic [31:0] ref_ext(input logic [1:0] md, input logic [15:0] d);
    int s;
    s = int'($signed(d));
    case (md)
      2'd0:    return 32'(s);
      2'd1:    return 32'(int'(d));
      2'd2:    return 32'(int'(d) * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic drive(input logic [1:0] md, input logic [15:0] d, input logic [4:0] t);
    in_valid = 1'b1;
    mode     = md;
    data_in  = d;
    tag_in   = t;
  endtask

  // One item through an idle pipe with out_ready=1, checked one edge later
  task automatic send_one(input string tag, input logic [1:0] md, input logic [15:0] d,
                          input logic [31:0] exp);
    drive(md, d, 5'd7);
    @(posedge clk); #1;
    check(tag, {out_valid, data_out}, {1'b1, exp});
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [36:0] exp_q[$];

  initial begin
    logic [1:0]  md;
    logic [15:0] d;
    logic [4:0]  t;
    logic [31:0] held_a;
    logic [4:0]  held_t;
    bit          acc, drn;
    int          issued, received, cycles;

    // ---- reset values ----
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out",  data_out,  0);
    check("rst_tag_out",   tag_out,   0);
    check("rst_in_ready",  in_ready,  1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // ---- 1: SIGN, one-cycle latency ----
    drive(2'd0, 16'h8001, 5'd3);
    #2;
    check("t1_pre_valid", out_valid, 0);
    @(posedge clk); #1;
    check("t1_valid", out_valid, 1);
    check("t1_data",  data_out, 32'hFFFF8001);
    check("t1_tag",   tag_out, 5'd3);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("t1_drained", out_valid, 0);

    // ---- 2: other modes ----
    send_one("t2_zero",   2'd1, 16'h8001, 32'h00008001);
    send_one("t2_upper",  2'd2, 16'h1234, 32'h12340000);
    send_one("t2_branch", 2'd3, 16'hFFFF, 32'hFFFFFFFC);
    send_one("t2_branch_pos", 2'd3, 16'h7FFF, 32'h0001FFFC);
    send_one("t2_sign_pos",   2'd0, 16'h7FFF, 32'h00007FFF);

    // ---- 3: 8 back-to-back with out_ready=1 ----
    for (int i = 0; i < 8; i++) begin
      md = 2'(i); d = 16'($urandom); t = 5'(i);
      drive(md, d, t);
      @(posedge clk); #1;
      check("t3_data", {out_valid, tag_out, data_out}, {1'b1, t, ref_ext(md, d)});
      check("t3_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("t3_drained", out_valid, 0);

    // ---- 4: stall, skid fill, release ----
    out_ready = 1'b0;
    drive(2'd0, 16'hA5A5, 5'd1);
    @(posedge clk); #1;
    check("t4_a_in", {out_valid, in_ready}, 2'b11);
    held_a = data_out; held_t = tag_out;
    check("t4_a_data", data_out, 32'hFFFFA5A5);
    drive(2'd2, 16'h00FF, 5'd2);
    @(posedge clk); #1;
    check("t4_in_ready_low", in_ready, 0);
    drive(2'd1, 16'hC3C3, 5'd4);       // offered while in_ready=0: must be ignored
    repeat (2) begin
      @(posedge clk); #1;
      check("t4_stable", {in_ready, tag_out, data_out}, {1'b0, held_t, held_a});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_b_out", {out_valid, tag_out, data_out}, {1'b1, 5'd2, 32'h00FF0000});
    check("t4_in_ready_back", in_ready, 1);
    @(posedge clk); #1;
    check("t4_c_out", {out_valid, tag_out, data_out}, {1'b1, 5'd4, 32'h0000C3C3});
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("t4_drained", out_valid, 0);

    // ---- 5: reset while skid full ----
    out_ready = 1'b0;
    drive(2'd0, 16'h1111, 5'd5);
    @(posedge clk); #1;
    drive(2'd0, 16'h2222, 5'd6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t5_full", {out_valid, in_ready}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_clear", {out_valid, in_ready, tag_out, data_out}, {2'b01, 5'd0, 32'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("t5_no_stale", out_valid, 0);
    end

    // ---- 6: random traffic against a FIFO scoreboard ----
    issued = 0; received = 0; cycles = 0;
    in_valid = 1'b0;
    while (received < 1000 && cycles < 20000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected", {tag_out, data_out}, 37'h1FFFFFFFFF);
        end else begin
          check("rnd_item", {tag_out, data_out}, exp_q.pop_front());
        end
        received++;
      end
      if (acc) exp_q.push_back({tag_in, ref_ext(mode, data_in)});
      @(posedge clk); #1;
      cycles++;
      if (acc || !in_valid) begin
        if (issued < 1000 && $urandom_range(0, 3) != 0) begin
          drive(2'($urandom), 16'($urandom), 5'($urandom));
          issued++;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    check("rnd_received", received, 1000);
    check("rnd_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
